// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: samples din on rising edges of the divided bit clock,
// assembles MSB-first frames and presents them through a valid/ack handshake.
module serial_frame_receiver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clkTx,
    input  logic                   dinValid,
    input  logic                   din,
    input  logic                   rxAck,
    output logic [3*WIDTH+8-1:0]   dataOut,
    output logic [WIDTH-1:0]       opA,
    output logic [WIDTH-1:0]       opB,
    output logic [WIDTH-1:0]       result,
    output logic [3:0]             opSel,
    output logic [3:0]             flags,
    output logic                   dataValid,
    output logic                   rxBusy,
    output logic                   frameErr,
    output logic                   overrun,
    output logic [7:0]             frameCnt
);
    localparam int FRAME_W = 3*WIDTH+8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clk_tx_q;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               rise;
    logic               last_bit;

    assign rise     = clkTx & ~clk_tx_q;
    assign last_bit = (cnt_q == CNT_W'(FRAME_W-1));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        valid_d     = valid_q;
        if (valid_q && rxAck) begin
            valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (rise && dinValid) begin
                    shift_d = {{(FRAME_W-1){1'b0}}, din};
                    cnt_d   = CNT_W'(1);
                    state_d = RECV;
                end
            end
            default: begin
                // Losing the qualifier aborts immediately, even on a sampling edge.
                if (!dinValid) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (rise) begin
                    shift_d = {shift_q[FRAME_W-2:0], din};
                    if (last_bit) begin
                        // Completion beats a same-cycle ack: the new frame stays valid.
                        data_d      = shift_d;
                        valid_d     = 1'b1;
                        overrun_d   = valid_q && !rxAck;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            clk_tx_q    <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            clk_tx_q    <= clkTx;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dataOut   = data_q;
    assign opA       = data_q[FRAME_W-1 -: WIDTH];
    assign opB       = data_q[FRAME_W-1-WIDTH -: WIDTH];
    assign result    = data_q[FRAME_W-1-2*WIDTH -: WIDTH];
    assign opSel     = data_q[7:4];
    assign flags     = data_q[3:0];
    assign dataValid = valid_q;
    assign rxBusy    = (state_q == RECV);
    assign frameErr  = frame_err_q;
    assign overrun   = overrun_q;
    assign frameCnt  = frame_cnt_q;

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receiving end of the ALU/memory serial link. Deserialises the 1-bit stream produced by the serial transceiver (DataOut, framed by DOutValid and clocked by clkTx) back into a 32-bit frame.
- Splits the frame into operand A, operand B, result, opcode and flags, and holds them for a consumer through a valid/ack handshake.
- Flags frames that are cut short and frames lost to overrun.
- Sits in the same clk domain as the transmitter, e.g. on a monitor/loopback board or a host-side interface.

Parameters:
- WIDTH, 8, operand/result width. Frame length FRAME_W = 3*WIDTH+8 (32 at default).
- CNT_W, 6, width of the bit counter. Must satisfy 2^CNT_W > FRAME_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clkTx  input  1  divided bit clock from the frequency divider. Sampled as a level in the clk domain.
- dinValid  input  1  frame-active qualifier (transmitter txBusy / DOutValid).
- din  input  1  serial data (transmitter dout / DataOut), MSB first.
- rxAck  input  1  consumer acknowledge; clears dataValid.
- dataOut  output  FRAME_W  last complete frame.
- opA  output  WIDTH  dataOut[FRAME_W-1 -: WIDTH].
- opB  output  WIDTH  next WIDTH bits.
- result  output  WIDTH  next WIDTH bits.
- opSel  output  4  dataOut[7:4].
- flags  output  4  dataOut[3:0].
- dataValid  output  1  frame held and not yet acknowledged.
- rxBusy  output  1  frame reception in progress.
- frameErr  output  1  one-cycle pulse: frame aborted.
- overrun  output  1  one-cycle pulse: frame completed while dataValid was still 1.
- frameCnt  output  8  count of good frames; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit count=0, clkTx_q=0. All outputs 0.
- Edge detect: clkTx_q registers clkTx every clk. rise = clkTx & ~clkTx_q (combinational). A bit is sampled only in a clk cycle where rise=1. Level-high clkTx without a rise samples nothing.
- States are IDLE and RECV.
- IDLE, rise=1 and dinValid=1:
  - shift in din as bit FRAME_W-1, count=1, go to RECV.
  - rxBusy=1 from the next cycle.
- IDLE, otherwise: no change. din is ignored.
- RECV, dinValid=0 in any clk cycle (not only at a rise):
  - abort: frameErr=1 for one cycle, count=0, go to IDLE.
  - dataOut and dataValid are unchanged; partial data is discarded.
- RECV, rise=1 and dinValid=1: shift = {shift[FRAME_W-2:0], din}, count+1.
- When the FRAME_W-th bit is sampled, all on the same clk edge:
  - dataOut <= completed shift value; dataValid <= 1; frameCnt+1.
  - count=0, go to IDLE, rxBusy=0.
  - If dataValid was already 1 and rxAck is not 1 that cycle: overrun=1 for one cycle; new data overwrites old.
- Latency: dataOut/dataValid are visible in the cycle after the clk edge that samples the last bit.
- Handshake: rxAck=1 while dataValid=1 clears dataValid on the next edge. rxAck while dataValid=0 is ignored.
- Simultaneous ack and completion: completion wins; dataValid stays 1 and no overrun.
- Back-to-back frames: if dinValid is still 1 at the first rise after completion, that rise starts the next frame from IDLE.
- Simultaneous abort and rise in RECV: abort wins; the bit is not sampled.
- Field outputs are continuous slices of dataOut, so they change only when a frame completes.
- rxBusy = (state==RECV).
- Reset asserted mid-frame: immediate return to reset values. No frameErr is generated.

Test Plan:
- Single frame: send 0xA53CE128 MSB-first at clkTx = clk/4, dinValid high for 32 rises -> dataValid=1 one cycle after the 32nd sampling edge; opA=0xA5, opB=0x3C, result=0xE1, opSel=0x2, flags=0x8, frameCnt=1, rxBusy=0.
- Handshake/overrun: send 0x00000001, hold rxAck=0, then send 0xFFFFFFFF -> overrun pulse on completion, dataOut=0xFFFFFFFF, frameCnt=2. Then rxAck=1 for 1 cycle -> dataValid=0 next cycle.
- Abort: drop dinValid after 17 bits of 0x12345678 -> frameErr pulse, rxBusy=0, dataOut keeps its previous value, frameCnt unchanged. A following full frame 0x12345678 is received correctly.
- Level, not edge: hold clkTx high for 10 clk cycles with dinValid=1 -> exactly one bit sampled (count=1).
- Back-to-back: two frames 0xDEADBEEF, 0xCAFEF00D with dinValid never dropping; ack at the first dataValid -> both received, no frameErr or overrun, frameCnt=2.
- Reset: assert reset at bit 20 -> all outputs 0 asynchronously. After release, frame 0x0F0F0F0F is received correctly with frameCnt=1.
